piso_serial_tx: RTL
===================

# piso_serial_tx

Parallel-in/serial-out transmitter that sources the serial bit streams consumed by the team's shift-register chains. It takes a WIDTH-bit word through a valid/ready handshake, shifts it onto a single serial line one bit per clock, and marks the data bits with a framing strobe and an end-of-word pulse. Back-to-back words stream with no idle cycle between them.

## Interface

Parameters:
- WIDTH, 8, word length in bits; legal range is 2 or more.
- MSB_FIRST, 1. When 1, bit WIDTH-1 is sent first. When 0, bit 0 is sent first.

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- din  in  WIDTH  parallel word; sampled only on an accepted handshake
- load_valid  in  1  producer has a word on din
- load_ready  out  1  transmitter can accept a word this cycle
- sout  out  1  serial data; idle level is 0
- sframe  out  1  high in every cycle where sout carries a data bit
- done  out  1  high only during the cycle that carries the last bit of a word

## Operation

- **State machine:** two states, IDLE and SHIFT, with a shift register of WIDTH bits and a bit counter of clog2(WIDTH) bits running 0..WIDTH-1.
- **Handshake acceptance:** a word is accepted on a rising edge where load_valid and load_ready are both 1.
- **load_ready:** equals rst AND (state is IDLE OR (state is SHIFT and counter is WIDTH-1)).
  - It is 0 while rst is low.
  - It stays high in IDLE independent of load_valid.
- **IDLE, word accepted:**
  - Load din into the shift register.
  - Clear the counter and go to SHIFT.
- **IDLE, no word accepted:** sout=0, sframe=0, done=0.
- **SHIFT:**
  - sout is the current first-out bit of the register.
  - sframe=1.
  - done=1 only when the counter is WIDTH-1.
- **SHIFT, counter below WIDTH-1:** each edge shifts the register toward the output end and increments the counter.
  - load_valid is ignored.
  - Changes on din have no effect.
- **SHIFT, counter at WIDTH-1, word accepted:** reload from din, clear the counter, stay in SHIFT. This gives a gapless stream.
- **SHIFT, counter at WIDTH-1, no word accepted:** go to IDLE.
- **Bit order:**
  - MSB_FIRST=1 sends din[WIDTH-1] down to din[0].
  - MSB_FIRST=0 sends din[0] up to din[WIDTH-1].
- **Registered outputs:** sout, sframe and done come straight from flops, with no combinational path from the inputs. load_ready is the only combinational output.
- **Reset:** rst low asynchronously forces state=IDLE, register=0, counter=0, sout=0, sframe=0, done=0 and load_ready=0.
- **Reset mid-word:** reset asserted in the middle of a word drops that word. No partial bits follow once rst is released.

## Timing

- **Latency:** a handshake at edge k drives the first bit on sout from edge k through edge k+1. Bit i is driven after edge k+i.
- **Last bit:** driven after edge k+WIDTH-1. done=1 and load_ready=1 in that same cycle.
- **Throughput:** one word per WIDTH cycles when load_valid is held high.
- **Idle return:** with no next word, sout, sframe and done return to 0 after edge k+WIDTH.
- **Reset release:** after rst deasserts, the first edge with load_valid=1 is accepted.

## Test plan

- **Single word, MSB first:** MSB_FIRST=1, WIDTH=8, one handshake with din=8'hA5.
  - sout reads 1,0,1,0,0,1,0,1 in consecutive cycles.
  - sframe is high for exactly 8 cycles.
  - done is high only in the 8th cycle.
  - sout, sframe and done are back to 0 in the 9th cycle.
- **Back-to-back words:** load_valid held high with 8'hA5 then 8'h3C.
  - 16 continuous sframe cycles.
  - sout reads 10100101 00111100.
  - load_ready is high only in the IDLE cycle and in the two last-bit cycles.
- **LSB first:** MSB_FIRST=0, din=8'h01.
  - sout reads 1 then seven 0s.
  - A following word 8'h80 gives seven 0s then 1.
- **Busy-time isolation:** during a word, pulse load_valid with din=8'hFF in bit cycles 2 to 5.
  - The transmitted word is unchanged.
  - No extra word is accepted.
- **Reset mid-word:** drop rst after 3 bits of 8'hFF.
  - sout, sframe, done and load_ready go to 0 immediately, without waiting for an edge.
  - After release with load_valid low, sout stays 0.
  - The next word 8'h81 is sent whole as 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter with a valid/ready load port.
// It emits one bit per clock, with a framing strobe and an end-of-word pulse, and streams gapless words.
module piso_serial_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sframe,
  output logic             done
);

  localparam int             CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  PENULT = CW'(WIDTH - 2);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             at_last;
  logic             accept;

  function automatic logic first_out(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign at_last    = (state == SHIFT) && (cnt == LAST);
  assign load_ready = rst && ((state == IDLE) || at_last);
  assign accept     = load_valid && load_ready;

  // sout is a flop of its own, so sreg holds only the bits that have not been sent yet
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      sout   <= 1'b0;
      sframe <= 1'b0;
      done   <= 1'b0;
    end else if (accept) begin
      state  <= SHIFT;
      sreg   <= advance(din);
      cnt    <= '0;
      sout   <= first_out(din);
      sframe <= 1'b1;
      done   <= 1'b0;
    end else if ((state == SHIFT) && !at_last) begin
      sreg   <= advance(sreg);
      cnt    <= cnt + CW'(1);
      sout   <= first_out(sreg);
      sframe <= 1'b1;
      done   <= (cnt == PENULT);
    end else begin
      state  <= IDLE;
      cnt    <= '0;
      sout   <= 1'b0;
      sframe <= 1'b0;
      done   <= 1'b0;
    end
  end

endmodule
